// File: rtl/map_tx_scheduler_pkg.sv
// Shared frame geometry defaults, scheduler state encoding and sizing helper
// for the sender-side payload scheduler.
package map_tx_scheduler_pkg;

  localparam int         DEF_FRAME_ROWS = 4;
  localparam int         DEF_FRAME_COLS = 4;
  localparam int         DEF_OH_COLS    = 1;
  localparam logic [7:0] DEF_FILL_BYTE  = 8'h00;

  localparam int ERR_TICK   = 0;
  localparam int ERR_DVALID = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/map_tx_scheduler_slot_pos_cnt.sv
// Row/column position of the current byte slot within a frame; advances once
// per completed slot and flags overhead columns and the frame wrap.
module map_tx_scheduler_slot_pos_cnt
  import map_tx_scheduler_pkg::*;
#(
  parameter int ROWS = DEF_FRAME_ROWS,
  parameter int COLS = DEF_FRAME_COLS,
  parameter int OH   = DEF_OH_COLS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic advance_i,
  output logic wrap_o,
  output logic overhead_o,
  output logic at_origin_o
);

  localparam int RW = cnt_width(ROWS);
  localparam int CW = cnt_width(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] OH_LIM   = CW'(OH);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          last;

  assign last        = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign wrap_o      = advance_i & last;
  assign overhead_o  = (col_q < OH_LIM);
  assign at_origin_o = (row_q == '0) && (col_q == '0);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (advance_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/map_tx_scheduler.sv
// Paces RX FIFO reads against serializer byte slots: one output byte per
// accepted slot, exactly two cycles after the tick, fill on overhead/underrun.
module map_tx_scheduler
  import map_tx_scheduler_pkg::*;
#(
  parameter int         FRAME_ROWS = DEF_FRAME_ROWS,
  parameter int         FRAME_COLS = DEF_FRAME_COLS,
  parameter int         OH_COLS    = DEF_OH_COLS,
  parameter logic [7:0] FILL_BYTE  = DEF_FILL_BYTE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_slot_tick,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_req,
  input  logic [7:0]  i_fifo_data,
  input  logic        i_fifo_data_valid,
  output logic [7:0]  o_pyld_data,
  output logic        o_pyld_data_valid,
  output logic        o_pyld_fill,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_underrun_cnt,
  output logic [1:0]  o_err
);

  sched_state_e state_q;
  logic         s1_vld_q, s1_rd_q, s2_vld_q;
  logic [7:0]   data_q;
  logic         fill_q;
  logic [15:0]  frame_cnt_q, underrun_cnt_q, underrun_cnt_d;
  logic [1:0]   err_q, err_d;
  logic         in_flight, running, accept, rd_req, underrun;
  logic         wrap, overhead, at_origin, busy;

  // A slot occupies T..T+2; s1/s2 mark T+1 and T+2 so a new tick is legal at T+3.
  assign in_flight = s1_vld_q | s2_vld_q;
  assign running   = (state_q != ST_IDLE) & ~i_rst;
  assign accept    = running & i_slot_tick & ~in_flight;
  assign rd_req    = accept & ~overhead & ~i_fifo_empty;
  assign underrun  = accept & ~overhead & i_fifo_empty;
  assign busy      = ~at_origin | in_flight | accept;

  map_tx_scheduler_slot_pos_cnt #(
    .ROWS(FRAME_ROWS),
    .COLS(FRAME_COLS),
    .OH  (OH_COLS)
  ) u_pos (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .advance_i  (s2_vld_q),
    .wrap_o     (wrap),
    .overhead_o (overhead),
    .at_origin_o(at_origin)
  );

  always_comb begin
    err_d = err_q;
    if (running && i_slot_tick && in_flight) err_d[ERR_TICK] = 1'b1;
    if (s1_rd_q && !i_fifo_data_valid)       err_d[ERR_DVALID] = 1'b1;
    underrun_cnt_d = underrun_cnt_q;
    if (underrun && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  // Disable is only honoured on a frame boundary; an idle origin stops at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_enable) state_q <= ST_RUN;
        ST_RUN: begin
          if (wrap)           state_q <= i_enable ? ST_RUN : ST_IDLE;
          else if (!i_enable) state_q <= busy ? ST_FLUSH : ST_IDLE;
        end
        ST_FLUSH: if (wrap) state_q <= i_enable ? ST_RUN : ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q       <= 1'b0;
      s1_rd_q        <= 1'b0;
      s2_vld_q       <= 1'b0;
      data_q         <= '0;
      fill_q         <= 1'b0;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
      err_q          <= '0;
    end else begin
      s1_vld_q       <= accept;
      s1_rd_q        <= rd_req;
      s2_vld_q       <= s1_vld_q;
      underrun_cnt_q <= underrun_cnt_d;
      err_q          <= err_d;
      if (s1_vld_q) begin
        if (s1_rd_q && i_fifo_data_valid) begin
          data_q <= i_fifo_data;
          fill_q <= 1'b0;
        end else begin
          data_q <= FILL_BYTE;
          fill_q <= 1'b1;
        end
      end
      if (wrap) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign o_fifo_rd_req     = rd_req;
  assign o_pyld_data       = data_q;
  assign o_pyld_data_valid = s2_vld_q;
  assign o_pyld_fill       = fill_q;
  assign o_busy            = busy;
  assign o_frame_cnt       = frame_cnt_q;
  assign o_underrun_cnt    = underrun_cnt_q;
  assign o_err             = err_q;

endmodule

// File: tb/tb_map_tx_scheduler.sv
// Directed bench for map_tx_scheduler: behavioural FIFO, per-strobe log and
// hand-computed frame contents for each scenario.
module tb_map_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, slot_tick, fifo_empty, fifo_rd_req, fifo_data_valid;
  logic [7:0]  fifo_data, pyld_data;
  logic        pyld_valid, pyld_fill, busy;
  logic [15:0] frame_cnt, underrun_cnt;
  logic [1:0]  err;

  always #5 clk = ~clk;

  map_tx_scheduler dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_slot_tick      (slot_tick),
    .i_fifo_empty     (fifo_empty),
    .o_fifo_rd_req    (fifo_rd_req),
    .i_fifo_data      (fifo_data),
    .i_fifo_data_valid(fifo_data_valid),
    .o_pyld_data      (pyld_data),
    .o_pyld_data_valid(pyld_valid),
    .o_pyld_fill      (pyld_fill),
    .o_busy           (busy),
    .o_frame_cnt      (frame_cnt),
    .o_underrun_cnt   (underrun_cnt),
    .o_err            (err)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] out_data[$];
  logic       out_fill[$];
  int         rd_cyc[$];
  int         vld_cyc[$];
  int         n_rd = 0;
  int         cyc_n = 0;
  int         withhold_idx = -1;
  logic       pend_valid = 1'b0;
  logic [7:0] pend_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive at posedge+1, observe at negedge, return at next posedge+1.
  task automatic cyc(input logic tick);
    slot_tick       = tick;
    fifo_empty      = (fifo_q.size() == 0);
    fifo_data_valid = pend_valid;
    fifo_data       = pend_valid ? pend_data : 8'hEE;
    pend_valid      = 1'b0;
    @(negedge clk);
    if (fifo_rd_req) begin
      rd_cyc.push_back(cyc_n);
      if (fifo_q.size() > 0) begin
        pend_data  = fifo_q.pop_front();
        pend_valid = (n_rd != withhold_idx);
      end
      n_rd++;
    end
    if (pyld_valid) begin
      out_data.push_back(pyld_data);
      out_fill.push_back(pyld_fill);
      vld_cyc.push_back(cyc_n);
      $display("t=%0t strobe data=%02h fill=%0b", $time, pyld_data, pyld_fill);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run_ticks(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      repeat (spacing - 1) cyc(1'b0);
    end
  endtask

  task automatic clear_log();
    out_data.delete();
    out_fill.delete();
    rd_cyc.delete();
    vld_cyc.delete();
    n_rd = 0;
  endtask

  task automatic load_fifo(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + 8'(i)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    pend_valid = 1'b0;
  endtask

  // Column 0 is overhead (fill); payload slots take FIFO bytes in order,
  // except read number skip_rd which was withheld and so comes out as fill.
  task automatic check_frame(input string tag, input logic [7:0] base, input int skip_rd,
                             input bit all_fill);
    int b = 0;
    logic [7:0] ed;
    logic       ef;
    check_eq({tag, "_strobes"}, 32'(out_data.size()), 32'd16);
    for (int k = 0; k < 16 && k < out_data.size(); k++) begin
      if ((k % 4) == 0 || all_fill) begin
        ed = 8'h00;
        ef = 1'b1;
      end else begin
        if (b == skip_rd) begin
          ed = 8'h00;
          ef = 1'b1;
        end else begin
          ed = 8'(base + 8'(b));
          ef = 1'b0;
        end
        b++;
      end
      check_eq($sformatf("%s_data%0d", tag, k), 32'(out_data[k]), 32'(ed));
      check_eq($sformatf("%s_fill%0d", tag, k), 32'(out_fill[k]), 32'(ef));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; slot_tick = 1'b0; fifo_empty = 1'b1;
    fifo_data = 8'hEE; fifo_data_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    cyc(1'b0);
    check_eq("rst_valid", 32'(pyld_valid), 32'd0);
    check_eq("rst_rd", 32'(fifo_rd_req), 32'd0);
    check_eq("rst_data", 32'(pyld_data), 32'd0);
    check_eq("rst_frame", 32'(frame_cnt), 32'd0);
    check_eq("rst_underrun", 32'(underrun_cnt), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // 1: full frame with 12 bytes available
    enable = 1'b1;
    cyc(1'b0);
    clear_log();
    load_fifo(8'h01, 12);
    run_ticks(2, 8);
    check_eq("t1_busy_mid", 32'(busy), 32'd1);
    run_ticks(14, 8);
    check_frame("t1", 8'h01, -1, 1'b0);
    check_eq("t1_frame", 32'(frame_cnt), 32'd1);
    check_eq("t1_underrun", 32'(underrun_cnt), 32'd0);
    check_eq("t1_rd", 32'(n_rd), 32'd12);
    check_eq("t1_busy_end", 32'(busy), 32'd0);

    // 2: FIFO empty for the whole frame
    clear_log();
    run_ticks(16, 8);
    check_frame("t2", 8'h00, -1, 1'b1);
    check_eq("t2_rd", 32'(n_rd), 32'd0);
    check_eq("t2_underrun", 32'(underrun_cnt), 32'd12);
    check_eq("t2_frame", 32'(frame_cnt), 32'd2);

    // 3: disable mid-frame; frame completes then scheduler idles
    clear_log();
    load_fifo(8'h20, 12);
    for (int k = 0; k < 16; k++) begin
      if (k == 5) enable = 1'b0;
      run_ticks(1, 8);
      if (k == 9) check_eq("t3_busy_flush", 32'(busy), 32'd1);
    end
    check_frame("t3", 8'h20, -1, 1'b0);
    check_eq("t3_frame", 32'(frame_cnt), 32'd3);
    check_eq("t3_busy", 32'(busy), 32'd0);
    clear_log();
    run_ticks(4, 8);
    check_eq("t3_idle_strobes", 32'(out_data.size()), 32'd0);
    check_eq("t3_idle_rd", 32'(n_rd), 32'd0);
    check_eq("t3_idle_frame", 32'(frame_cnt), 32'd3);

    // 4: ticks every 2 clocks; every second one is dropped
    enable = 1'b1;
    cyc(1'b0);
    clear_log();
    load_fifo(8'h30, 12);
    run_ticks(32, 2);
    repeat (4) cyc(1'b0);
    check_frame("t4", 8'h30, -1, 1'b0);
    check_eq("t4_rd", 32'(n_rd), 32'd12);
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_frame", 32'(frame_cnt), 32'd4);
    for (int i = 0; i < rd_cyc.size(); i++) begin
      int hits[$];
      hits = vld_cyc.find_index with (item == rd_cyc[i] + 2);
      check_eq($sformatf("t4_latency%0d", i), 32'(hits.size()), 32'd1);
    end

    do_reset();
    check_eq("t4_rst_err", 32'(err), 32'd0);
    check_eq("t4_rst_frame", 32'(frame_cnt), 32'd0);

    // 5: third read gets no data_valid; its byte is lost, not replayed
    cyc(1'b0);
    clear_log();
    load_fifo(8'h40, 12);
    withhold_idx = 2;
    run_ticks(16, 8);
    withhold_idx = -1;
    check_frame("t5", 8'h40, 2, 1'b0);
    check_eq("t5_err", 32'(err), 32'd2);
    check_eq("t5_underrun", 32'(underrun_cnt), 32'd0);
    check_eq("t5_rd", 32'(n_rd), 32'd12);
    check_eq("t5_frame", 32'(frame_cnt), 32'd1);

    // 6: reset one cycle after slot 7's read; its strobe must not appear
    clear_log();
    load_fifo(8'h50, 12);
    run_ticks(7, 8);
    cyc(1'b1);
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    cyc(1'b0);
    check_eq("t6_strobes", 32'(out_data.size()), 32'd7);
    check_eq("t6_rd", 32'(n_rd), 32'd6);
    check_eq("t6_frame", 32'(frame_cnt), 32'd0);
    check_eq("t6_underrun", 32'(underrun_cnt), 32'd0);
    check_eq("t6_err", 32'(err), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    clear_log();
    run_ticks(4, 8);
    check_eq("t6_re_strobes", 32'(out_data.size()), 32'd4);
    if (out_data.size() == 4) begin
      check_eq("t6_re_fill0", 32'(out_fill[0]), 32'd1);
      check_eq("t6_re_data1", 32'(out_data[1]), 32'h56);
      check_eq("t6_re_data2", 32'(out_data[2]), 32'h57);
      check_eq("t6_re_data3", 32'(out_data[3]), 32'h58);
    end
    check_eq("t6_re_rd", 32'(n_rd), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
